// File: rtl/rvx_wb_pkg.sv
// Shared types and constants for the rvx core to Wishbone classic bridge.
package rvx_wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } bridge_state_t;

   localparam logic [31:0] READ_ERROR_DATA = 32'h0;

endpackage

// File: rtl/rvx_wb_bridge.sv
// Registered bridge: one Wishbone classic cycle per core request, one-cycle
// response pulse, and a timeout abort that reports bus_error.
module rvx_wb_bridge
   import rvx_wb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   rw_address,
   input  logic [DATA_WIDTH-1:0]   write_data,
   input  logic [DATA_WIDTH/8-1:0] write_strobe,
   input  logic                    read_request,
   input  logic                    write_request,
   output logic [DATA_WIDTH-1:0]   read_data,
   output logic                    read_response,
   output logic                    write_response,
   output logic                    bus_error,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                    wb_ack_i
);

   localparam int SEL_W = DATA_WIDTH / 8;
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   bridge_state_t           r_state;
   bridge_state_t           w_next;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_cyc;
   logic                    r_we;
   logic [ADDR_WIDTH-1:0]   r_adr;
   logic [DATA_WIDTH-1:0]   r_dat;
   logic [SEL_W-1:0]        r_sel;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic                    r_rd_resp;
   logic                    r_wr_resp;
   logic                    r_err;

   logic                    w_timeout;
   logic                    w_done;
   logic                    w_cyc_d;
   logic                    w_rd_resp_d;
   logic                    w_wr_resp_d;
   logic                    w_err_d;

   // An ack in the last allowed cycle wins over the timeout.
   assign w_timeout = TO_EN && (r_state == BUS) && !wb_ack_i && (r_cnt == CNT_LAST);
   assign w_done    = (r_state == BUS) && (wb_ack_i || w_timeout);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (write_request || read_request) w_next = BUS;
         BUS:     if (wb_ack_i || w_timeout) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_cyc_d     = (w_next == BUS);
      w_rd_resp_d = w_done && !r_we;
      w_wr_resp_d = w_done && r_we;
      w_err_d     = w_timeout;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_cyc     <= 1'b0;
         r_we      <= 1'b0;
         r_adr     <= '0;
         r_dat     <= '0;
         r_sel     <= '0;
         r_rdata   <= '0;
         r_rd_resp <= 1'b0;
         r_wr_resp <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_cyc     <= w_cyc_d;
         r_rd_resp <= w_rd_resp_d;
         r_wr_resp <= w_wr_resp_d;
         r_err     <= w_err_d;
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (write_request) begin
                  r_we  <= 1'b1;
                  r_adr <= rw_address;
                  r_dat <= write_data;
                  r_sel <= write_strobe;
               end else if (read_request) begin
                  r_we  <= 1'b0;
                  r_adr <= rw_address;
                  r_sel <= '1;
               end
            end
            BUS: begin
               if (wb_ack_i) begin
                  if (!r_we) r_rdata <= wb_dat_i;
               end else if (w_timeout) begin
                  r_rdata <= DATA_WIDTH'(READ_ERROR_DATA);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign wb_cyc_o       = r_cyc;
   assign wb_stb_o       = r_cyc;
   assign wb_we_o        = r_we;
   assign wb_adr_o       = r_adr;
   assign wb_dat_o       = r_dat;
   assign wb_sel_o       = r_sel;
   assign read_data      = r_rdata;
   assign read_response  = r_rd_resp;
   assign write_response = r_wr_resp;
   assign bus_error      = r_err;

endmodule

// File: tb/tb_rvx_wb_bridge.sv
// Directed bench for rvx_wb_bridge with a 4-cycle timeout; outputs are
// sampled 1 time unit after each rising edge.
module tb_rvx_wb_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rw_address;
   logic [31:0] write_data;
   logic [3:0]  write_strobe;
   logic        read_request;
   logic        write_request;
   logic [31:0] read_data;
   logic        read_response;
   logic        write_response;
   logic        bus_error;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;

   int n_checks = 0;
   int n_errors = 0;

   rvx_wb_bridge #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rw_address     (rw_address),
      .write_data     (write_data),
      .write_strobe   (write_strobe),
      .read_request   (read_request),
      .write_request  (write_request),
      .read_data      (read_data),
      .read_response  (read_response),
      .write_response (write_response),
      .bus_error      (bus_error),
      .wb_cyc_o       (wb_cyc_o),
      .wb_stb_o       (wb_stb_o),
      .wb_we_o        (wb_we_o),
      .wb_adr_o       (wb_adr_o),
      .wb_dat_o       (wb_dat_o),
      .wb_sel_o       (wb_sel_o),
      .wb_dat_i       (wb_dat_i),
      .wb_ack_i       (wb_ack_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Response bundle {read_response, write_response, bus_error}.
   function automatic logic [2:0] resp();
      return {read_response, write_response, bus_error};
   endfunction

   initial begin
      rst = 1'b1; rw_address = '0; write_data = '0; write_strobe = '0;
      read_request = 1'b0; write_request = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0;
      step(); step();
      chk("rst_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
      chk("rst_adr", wb_adr_o, 32'h0);
      chk("rst_dat", wb_dat_o, 32'h0);
      chk("rst_sel", wb_sel_o, 4'h0);
      chk("rst_rdata", read_data, 32'h0);
      chk("rst_resp", resp(), 3'b000);
      rst = 1'b0;
      step();

      // Read, slave acks in cycle 3
      rw_address = 32'h0000_0040; read_request = 1'b1;
      step();
      chk("rd_c1_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b110);
      chk("rd_c1_sel", wb_sel_o, 4'hF);
      chk("rd_c1_adr", wb_adr_o, 32'h0000_0040);
      step();
      chk("rd_c2_cyc", wb_cyc_o, 1'b1);
      step();
      chk("rd_c3_cyc", wb_cyc_o, 1'b1);
      chk("rd_c3_resp", resp(), 3'b000);
      wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
      step();
      wb_ack_i = 1'b0; wb_dat_i = 32'hDEAD_BEEF;
      chk("rd_c4_cyc", wb_cyc_o, 1'b0);
      chk("rd_c4_resp", resp(), 3'b100);
      chk("rd_c4_data", read_data, 32'h1234_5678);
      read_request = 1'b0;
      step();
      chk("rd_c5_resp", resp(), 3'b000);
      chk("rd_c5_cyc", wb_cyc_o, 1'b0);

      // Zero-wait write with partial strobes
      rw_address = 32'h0000_0100; write_data = 32'hCAFE_F00D; write_strobe = 4'b0011;
      write_request = 1'b1;
      step();
      chk("wr_c1_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b111);
      chk("wr_c1_sel", wb_sel_o, 4'b0011);
      chk("wr_c1_adr", wb_adr_o, 32'h0000_0100);
      chk("wr_c1_dat", wb_dat_o, 32'hCAFE_F00D);
      wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
      step();
      wb_ack_i = 1'b0;
      chk("wr_c2_cyc", wb_cyc_o, 1'b0);
      chk("wr_c2_resp", resp(), 3'b010);
      chk("wr_c2_rdata", read_data, 32'h1234_5678);
      write_request = 1'b0;
      step();
      chk("wr_c3_resp", resp(), 3'b000);

      // Both requests at once: write first, then the read
      rw_address = 32'h0000_0200; write_data = 32'h0BAD_F00D; write_strobe = 4'b1100;
      write_request = 1'b1; read_request = 1'b1;
      step();
      chk("both_c1_cyc", {wb_cyc_o, wb_we_o}, 2'b11);
      chk("both_c1_sel", wb_sel_o, 4'b1100);
      wb_ack_i = 1'b1;
      step();
      wb_ack_i = 1'b0;
      chk("both_c2_resp", resp(), 3'b010);
      chk("both_c2_cyc", wb_cyc_o, 1'b0);
      write_request = 1'b0;
      step();
      chk("both_c3_cyc", wb_cyc_o, 1'b0);
      chk("both_c3_resp", resp(), 3'b000);
      step();
      chk("both_c4_cyc", {wb_cyc_o, wb_we_o}, 2'b10);
      chk("both_c4_sel", wb_sel_o, 4'hF);
      wb_ack_i = 1'b1; wb_dat_i = 32'h8765_4321;
      step();
      wb_ack_i = 1'b0;
      chk("both_c5_resp", resp(), 3'b100);
      chk("both_c5_data", read_data, 32'h8765_4321);
      read_request = 1'b0;
      step();
      chk("both_c6_resp", resp(), 3'b000);

      // Timeout with no ack: cyc high for exactly 4 cycles
      rw_address = 32'h0000_0300; read_request = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         step();
         chk($sformatf("to_c%0d_cyc", c), {wb_cyc_o, read_response}, 2'b10);
      end
      step();
      chk("to_c5_cyc", wb_cyc_o, 1'b0);
      chk("to_c5_resp", resp(), 3'b101);
      chk("to_c5_data", read_data, 32'h0);
      read_request = 1'b0;
      step();
      chk("to_c6_resp", resp(), 3'b000);
      chk("to_c6_cyc", wb_cyc_o, 1'b0);

      // Ack in the cycle the timeout would fire
      rw_address = 32'h0000_0400; read_request = 1'b1;
      step(); step(); step(); step();
      chk("race_c4_cyc", wb_cyc_o, 1'b1);
      wb_ack_i = 1'b1; wb_dat_i = 32'hAA55_AA55;
      step();
      wb_ack_i = 1'b0;
      chk("race_c5_resp", resp(), 3'b100);
      chk("race_c5_data", read_data, 32'hAA55_AA55);
      read_request = 1'b0;
      step();

      // Reset in the middle of a bus cycle, then a normal zero-wait read
      rw_address = 32'h0000_0500; read_request = 1'b1;
      step();
      chk("rb_c1_cyc", wb_cyc_o, 1'b1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rb_c3_cyc", wb_cyc_o, 1'b0);
      chk("rb_c3_resp", resp(), 3'b000);
      chk("rb_c3_adr", wb_adr_o, 32'h0);
      step();
      chk("rb_c4_cyc", wb_cyc_o, 1'b1);
      chk("rb_c4_resp", resp(), 3'b000);
      chk("rb_c4_adr", wb_adr_o, 32'h0000_0500);
      wb_ack_i = 1'b1; wb_dat_i = 32'h0F0F_0F0F;
      step();
      wb_ack_i = 1'b0;
      chk("rb_c5_resp", resp(), 3'b100);
      chk("rb_c5_data", read_data, 32'h0F0F_0F0F);
      read_request = 1'b0;
      step();
      chk("rb_c6_resp", resp(), 3'b000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rvx_wb_bridge.md
# rvx_wb_bridge

Registered bridge between the rvx core's level-request / pulse-response memory port and a single Wishbone classic master port. It replaces the ad-hoc glue in the processor top: the core's address, data and strobes go in on one side, and the Controller (or a second data memory) hangs off the other. The bridge issues one Wishbone cycle per core request, returns read data with a one-cycle response pulse, and aborts stalled cycles with a timeout error.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width on both sides
- DATA_WIDTH, 32, data width; byte-select width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 255, bus cycles allowed before abort; 0 disables the timeout

Ports:
- clk  in  1  single clock; every register in the block uses its rising edge
- rst  in  1  reset: synchronous, active-high
- rw_address  in  ADDR_WIDTH  core address, valid while a request is high
- write_data  in  DATA_WIDTH  core write data
- write_strobe  in  DATA_WIDTH/8  core byte enables for writes
- read_request  in  1  core read request, level, held until read_response
- write_request  in  1  core write request, level, held until write_response
- read_data  out  DATA_WIDTH  captured read data, valid while read_response is high
- read_response  out  1  one-cycle read completion pulse
- write_response  out  1  one-cycle write completion pulse
- bus_error  out  1  one-cycle pulse, coincident with the response of a timed-out access
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle/strobe; always equal to each other
- wb_we_o  out  1  1 = write
- wb_adr_o  out  ADDR_WIDTH  Wishbone address
- wb_dat_o  out  DATA_WIDTH  Wishbone write data
- wb_sel_o  out  DATA_WIDTH/8  byte selects; all ones on reads
- wb_dat_i  in  DATA_WIDTH  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - If write_request is high, latch address, data and strobes, set we=1, and go to BUS.
  - Else if read_request is high, latch the address, set sel all ones and we=0, and go to BUS.
  - Write has priority when both requests are high. The losing request stays high and is served after the RESP state.
- BUS: cyc/stb are high and the Wishbone outputs are held stable.
  - On wb_ack_i: drop cyc/stb, capture wb_dat_i into read_data (reads only), go to RESP.
  - On timeout: drop cyc/stb, set read_data to 0, go to RESP with the error flag set.
- RESP: pulse exactly one of read_response/write_response, plus bus_error if flagged. Go to IDLE unconditionally.
  - RESP never samples requests. This gives the core one cycle to drop its request, so a stale request cannot be re-issued.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1). Cleared on entry to BUS and incremented every BUS cycle without ack. Timeout fires when the count equals TIMEOUT_CYCLES-1 and ack is low.
- An ack arriving in the same cycle as the timeout wins: normal completion, no error.
- wb_ack_i outside BUS is ignored.
- The request inputs and wb_dat_i are not sampled in any state other than the ones above.

## Timing
- Reset: state IDLE; all outputs 0, including wb_sel_o, wb_adr_o, wb_dat_o and read_data; counter 0. Reset during BUS drops cyc/stb on the next edge with no response pulse.
- Request high in cycle 0 → wb_cyc_o high from cycle 1.
- wb_ack_i high in cycle k → cyc low and response pulse high in cycle k+1 → IDLE in cycle k+2.
- Zero-wait slave (ack in cycle 1): response in cycle 2. A new request held in cycle 2 is accepted at the edge ending cycle 3, so cyc is high again in cycle 4. Best-case throughput is one access per 3 cycles.
- Timeout with TIMEOUT_CYCLES=N: cyc is high for exactly N cycles, then response + bus_error are high for 1 cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package rvx_wb_pkg holds the state enum (bridge_state_t: IDLE, BUS, RESP) and the READ_ERROR_DATA constant (32'h0).
- No sub-module is needed; the timeout counter is inline. Expected implementation is about 150 lines.
- Intended use: instantiated in processorci_top between rvx_core and the Controller bus signals.

## Test plan
- Read, slave acks in cycle 3 with 32'h1234_5678 → cyc high in cycles 1-3; read_data=32'h1234_5678 and read_response=1 in cycle 4 only; wb_sel_o=4'hF.
- Write to 32'h0000_0100, data 32'hCAFE_F00D, strobe 4'b0011, zero-wait ack → we=1, sel=4'b0011 during BUS; write_response pulses in cycle 2; no read_response.
- read_request and write_request both high in cycle 0, each held until its response → write cycle completes first, then the read; the RESP cycle separates the two bus cycles.
- TIMEOUT_CYCLES=4, no ack → cyc high for exactly 4 cycles, then read_response=1, bus_error=1, read_data=0 for one cycle; back to IDLE.
- Ack and timeout in the same cycle → normal response, bus_error=0. Separately, rst asserted mid-BUS → cyc low next cycle, no response pulse, next request is served normally.
